loop_addr_engine: RTL

Parametrised loop-stack and address-generation engine that replaces the fixed 8-deep, 8-APU loop/APU logic inside the control unit. The decoder side issues LOAD_APU, LOOP_START and LOOP_END commands over a valid/ready handshake. The engine keeps a loop stack and APU address registers, and returns one response per command: the PC jump and the superscalar lane count. Other pipeline stages read APU addresses and per-loop strides through a combinational query port. New relative to the current control unit: backpressure, chunked independent loops with exact tail handling, address restore on exit, and error responses instead of silent corruption.

---
 rtl/loop_addr_engine_if.sv | 39 +++
 rtl/loop_addr_engine.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/loop_addr_engine_if.sv
// Command and response channels between the decoder and the loop/address engine.
interface loop_addr_engine_if #(
  parameter int LOOP_DEPTH = 8,
  parameter int APU_CNT    = 8,
  parameter int ADDR_W     = 18,
  parameter int ITER_W     = 18,
  parameter int JUMP_W     = 6,
  parameter int LOG_SS     = 3
);
  localparam int AW = (APU_CNT > 1) ? $clog2(APU_CNT) : 1;

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [1:0]                   cmd_op;
  logic [AW-1:0]                cmd_apu_sel;
  logic [LOOP_DEPTH*ADDR_W-1:0] cmd_coeffs;
  logic [ADDR_W-1:0]            cmd_const;
  logic [ITER_W-1:0]            cmd_iter;
  logic [JUMP_W-1:0]            cmd_jump;
  logic                         cmd_indep;

  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [JUMP_W-1:0]            rsp_jump;
  logic [LOG_SS:0]              rsp_lanes;
  logic                         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_apu_sel, cmd_coeffs, cmd_const,
           cmd_iter, cmd_jump, cmd_indep, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_jump, rsp_lanes, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_apu_sel, cmd_coeffs, cmd_const,
           cmd_iter, cmd_jump, cmd_indep, rsp_ready,
    output cmd_ready, rsp_valid, rsp_jump, rsp_lanes, rsp_err
  );
endinterface

// File: rtl/loop_addr_engine.sv
// Loop stack + APU address engine; response 1 cycle after accept (2 for LOOP_END).
// One command in flight: cmd_ready only in IDLE, response held until rsp_ready.
module loop_addr_engine #(
  parameter int LOOP_DEPTH = 8,
  parameter int APU_CNT    = 8,
  parameter int ADDR_W     = 18,
  parameter int ITER_W     = 18,
  parameter int JUMP_W     = 6,
  parameter int LOG_SS     = 3,
  localparam int LW        = $clog2(LOOP_DEPTH),
  localparam int AW        = (APU_CNT > 1) ? $clog2(APU_CNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  loop_addr_engine_if.slave bus,
  input  logic [AW-1:0]     q_apu,
  output logic [ADDR_W-1:0] q_addr,
  output logic [ADDR_W-1:0] q_stride,
  output logic [LW:0]       depth,
  output logic              error,
  output logic [1:0]        err_code
);
  typedef enum logic [1:0] {IDLE, UPDATE, RESP} state_t;

  localparam logic [1:0]      OP_LOAD  = 2'd1;
  localparam logic [1:0]      OP_START = 2'd2;
  localparam logic [1:0]      OP_END   = 2'd3;
  localparam int              SS       = 1 << LOG_SS;
  localparam logic [ITER_W:0] SS_I     = (ITER_W+1)'(SS);
  localparam logic [LOG_SS:0] SS_L     = (LOG_SS+1)'(SS);
  localparam logic [LOG_SS:0] ONE_L    = (LOG_SS+1)'(1);
  localparam logic [LW:0]     FULL     = (LW+1)'(LOOP_DEPTH);
  localparam logic [LW:0]     ONE_D    = (LW+1)'(1);

  state_t            state_q;
  logic [ITER_W-1:0] v_q     [LOOP_DEPTH];
  logic [ITER_W-1:0] t_q     [LOOP_DEPTH];
  logic [JUMP_W-1:0] jmp_q   [LOOP_DEPTH];
  logic              indep_q [LOOP_DEPTH];
  logic [LOG_SS:0]   lanes_q [LOOP_DEPTH];
  logic [ADDR_W-1:0] addr_q  [APU_CNT];
  logic [ADDR_W-1:0] coeff_q [APU_CNT][LOOP_DEPTH];
  logic [LW:0]       depth_q;
  logic              error_q;
  logic [1:0]        err_code_q;
  logic [JUMP_W-1:0] rsp_jump_q;
  logic [LOG_SS:0]   rsp_lanes_q;
  logic              rsp_err_q;

  logic [LW-1:0]     top;
  logic [LW-1:0]     push;
  logic [ITER_W:0]   v_next;
  logic [ITER_W:0]   rem;
  logic              cont;
  logic [LOG_SS:0]   cont_lanes;
  logic [LOG_SS:0]   start_lanes;
  logic [ADDR_W-1:0] delta;
  logic [1:0]        err_d;

  always_comb begin
    top         = LW'(depth_q - ONE_D);
    push        = LW'(depth_q);
    v_next      = {1'b0, v_q[top]} + (ITER_W+1)'(lanes_q[top]);
    cont        = v_next < {1'b0, t_q[top]};
    rem         = {1'b0, t_q[top]} - v_next;
    cont_lanes  = ONE_L;
    if (indep_q[top])
      cont_lanes = (rem > SS_I) ? SS_L : (LOG_SS+1)'(rem);
    start_lanes = ONE_L;
    if (bus.cmd_indep)
      start_lanes = ({1'b0, bus.cmd_iter} > SS_I) ? SS_L : (LOG_SS+1)'(bus.cmd_iter);
    // Exit rewinds by the full progress so addresses return to their pre-loop values.
    delta = cont ? ADDR_W'(lanes_q[top]) : ADDR_W'(0) - ADDR_W'(v_q[top]);
    err_d = 2'd0;
    if (bus.cmd_op == OP_START) begin
      if (depth_q == FULL)             err_d = 2'd1;
      else if (bus.cmd_iter == '0)     err_d = 2'd3;
    end else if (bus.cmd_op == OP_END) begin
      if (depth_q == '0)               err_d = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      error_q     <= 1'b0;
      err_code_q  <= 2'd0;
      rsp_jump_q  <= '0;
      rsp_lanes_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int d = 0; d < LOOP_DEPTH; d++) begin
        v_q[d]     <= '0;
        t_q[d]     <= '0;
        jmp_q[d]   <= '0;
        indep_q[d] <= 1'b0;
        lanes_q[d] <= '0;
      end
      for (int k = 0; k < APU_CNT; k++) begin
        addr_q[k] <= '0;
        for (int d = 0; d < LOOP_DEPTH; d++) coeff_q[k][d] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            rsp_jump_q  <= '0;
            rsp_lanes_q <= '0;
            rsp_err_q   <= 1'b0;
            state_q     <= RESP;
            if (err_d != 2'd0) begin
              rsp_err_q <= 1'b1;
              error_q   <= 1'b1;
              if (!error_q) err_code_q <= err_d;
            end else begin
              case (bus.cmd_op)
                OP_LOAD: begin
                  addr_q[bus.cmd_apu_sel] <= bus.cmd_const;
                  for (int d = 0; d < LOOP_DEPTH; d++)
                    coeff_q[bus.cmd_apu_sel][d] <= bus.cmd_coeffs[d*ADDR_W +: ADDR_W];
                end
                OP_START: begin
                  v_q[push]     <= '0;
                  t_q[push]     <= bus.cmd_iter;
                  jmp_q[push]   <= bus.cmd_jump;
                  indep_q[push] <= bus.cmd_indep;
                  lanes_q[push] <= start_lanes;
                  depth_q       <= depth_q + ONE_D;
                  rsp_lanes_q   <= start_lanes;
                end
                OP_END:  state_q <= UPDATE;
                default: ;
              endcase
            end
          end
        end
        UPDATE: begin
          for (int k = 0; k < APU_CNT; k++)
            addr_q[k] <= addr_q[k] + delta * coeff_q[k][top];
          if (cont) begin
            v_q[top]     <= v_next[ITER_W-1:0];
            lanes_q[top] <= cont_lanes;
            rsp_jump_q   <= jmp_q[top];
            rsp_lanes_q  <= cont_lanes;
          end else begin
            depth_q <= depth_q - ONE_D;
          end
          state_q <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_jump  = rsp_jump_q;
  assign bus.rsp_lanes = rsp_lanes_q;
  assign bus.rsp_err   = rsp_err_q;
  assign q_addr        = addr_q[q_apu];
  assign q_stride      = (depth_q == '0) ? '0 : coeff_q[q_apu][top];
  assign depth         = depth_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
endmodule
